// File: rtl/iic_byte_writer.sv
`default_nettype none
// ============================================================================
// iic_byte_writer : I2C master byte write engine paced by a quarter-SCL tick
// Rev 1.0
// ============================================================================
module iic_byte_writer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          gen_start,
  input  logic          gen_stop,
  input  logic [DW-1:0] din,
  input  logic          sda_in,
  output logic          ready,
  output logic          done,
  output logic          ack_err,
  output logic          scl,
  output logic          sda_oe
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    q_q, q_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [DW-1:0] data_q, data_d;
  logic          stop_q, stop_d;
  logic          held_q, held_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ackerr_q, ackerr_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;

  // Line levels {scl, sda_oe} for a given segment/phase.
  function automatic logic [1:0] seg_out(state_t st, logic [1:0] q, logic b, logic held);
    logic [1:0] r;
    case (st)
      S_START: begin
        case (q)
          2'd0:    r = {~held, 1'b0};
          2'd1:    r = 2'b10;
          2'd2:    r = 2'b11;
          default: r = 2'b01;
        endcase
      end
      S_BIT:   r = {(q == 2'd1) || (q == 2'd2), ~b};
      S_ACK:   r = {(q == 2'd1) || (q == 2'd2), 1'b0};
      S_STOP: begin
        case (q)
          2'd0:    r = 2'b01;
          2'd1:    r = 2'b11;
          2'd2:    r = 2'b11;
          default: r = 2'b10;
        endcase
      end
      default: r = held ? 2'b01 : 2'b10;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    bit_d    = bit_q;
    data_d   = data_q;
    stop_d   = stop_q;
    held_d   = held_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    ackerr_d = ackerr_q;
    if (ready_q) begin
      if (start) begin
        data_d   = din;
        stop_d   = gen_stop;
        ackerr_d = 1'b0;
        ready_d  = 1'b0;
        q_d      = 2'd0;
        bit_d    = CW'(DW - 1);
        state_d  = gen_start ? S_START : S_BIT;
      end
    end else if (tick) begin
      q_d = q_q + 2'd1;
      if (state_q == S_ACK && q_q == 2'd1) ackerr_d = sda_in;
      if (q_q == 2'd3) begin
        case (state_q)
          S_START: state_d = S_BIT;
          S_BIT: begin
            if (bit_q == '0) state_d = S_ACK;
            else             bit_d   = bit_q - CW'(1);
          end
          S_ACK:   state_d = stop_q ? S_STOP : S_IDLE;
          default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          held_d  = ~stop_q;
        end
      end
    end
    // Outputs registered from the next segment/phase so they line up with it.
    {scl_d, oe_d} = seg_out(state_d, q_d, data_d[bit_d], held_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      q_q      <= 2'd0;
      bit_q    <= '0;
      data_q   <= '0;
      stop_q   <= 1'b0;
      held_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
      scl_q    <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      stop_q   <= stop_d;
      held_q   <= held_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ackerr_q <= ackerr_d;
      scl_q    <= scl_d;
      oe_q     <= oe_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign ack_err = ackerr_q;
  assign scl     = scl_q;
  assign sda_oe  = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_byte_writer.sv
`default_nettype none
// ============================================================================
// tb_iic_byte_writer : directed self-checking bench for iic_byte_writer
// Rev 1.0
// ============================================================================
module tb_iic_byte_writer;

  logic       clk = 1'b0;
  logic       rst, tick, start, gen_start, gen_stop, sda_in;
  logic [7:0] din;
  logic       ready, done, ack_err, scl, sda_oe;

  iic_byte_writer #(.DW(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .gen_start(gen_start), .gen_stop(gen_stop), .din(din), .sda_in(sda_in),
    .ready(ready), .done(done), .ack_err(ack_err), .scl(scl), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  div = 2'd0;
  logic        tick_run = 1'b0;
  int          tick_cnt = 0;
  logic        last_tick = 1'b0;
  logic        p_scl = 1'b1, p_oe = 1'b0;
  logic [15:0] rises = '0;
  int          nrise = 0, start_seen = 0, stop_seen = 0, done_cnt = 0;
  int          done_len = 0;
  logic        done_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (scl && !p_scl) begin
      rises = {rises[14:0], ~sda_oe};
      nrise++;
    end
    if (scl && p_scl && sda_oe && !p_oe) start_seen++;
    if (scl && p_scl && !sda_oe && p_oe) stop_seen++;
    if (done) begin
      done_cnt++;
      done_len  = tick_cnt;
      done_last = last_tick;
    end
    p_scl = scl;
    p_oe  = sda_oe;
  endtask

  // Inputs are applied just after a falling edge, outputs observed at the next one.
  task automatic step();
    if (tick_run) begin
      tick = (div == 2'd3);
      div  = div + 2'd1;
    end else begin
      tick = 1'b0;
    end
    if (!rst) begin
      if (ready && start)      tick_cnt = 0;
      else if (!ready && tick) tick_cnt++;
    end
    last_tick = !rst && !ready && tick;
    @(negedge clk);
    observe();
  endtask

  task automatic clear_mon();
    rises = '0; nrise = 0; start_seen = 0; stop_seen = 0;
  endtask

  task automatic run_txn(input string nm, input logic [7:0] d, input logic gp, input logic nack,
                         input logic same_tick, input logic busy_poke, input int exp_len,
                         input logic [15:0] exp_rises, input int exp_nr, input int exp_stop,
                         input logic exp_first_scl);
    int  d0;
    bit  got;
    din = d; gen_start = 1'b1; gen_stop = gp; sda_in = nack;
    if (same_tick) begin
      for (int i = 0; i < 8 && div != 2'd3; i++) step();
    end
    clear_mon();
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    din = ~d;
    chk({nm, "_q0_scl"}, scl, exp_first_scl);
    chk({nm, "_accept_ackerr"}, ack_err, 1'b0);
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      if (busy_poke && n == 20) begin
        start = 1'b1; din = 8'h00;
      end
      step();
      start = 1'b0;
      got = (done_cnt != d0);
    end
    chk({nm, "_timeout"}, !got, 1'b0);
    chk({nm, "_len"}, done_len, exp_len);
    chk({nm, "_done_after_tick"}, done_last, 1'b1);
    chk({nm, "_rises"}, rises, exp_rises);
    chk({nm, "_nrise"}, nrise, exp_nr);
    chk({nm, "_start"}, start_seen, 1);
    chk({nm, "_stop"}, stop_seen, exp_stop);
    chk({nm, "_ackerr"}, ack_err, nack);
    chk({nm, "_ready"}, ready, 1'b1);
    step();
    chk({nm, "_done_1cyc"}, done, 1'b0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; tick = 1'b0; start = 1'b0; gen_start = 1'b0; gen_stop = 1'b0;
    sda_in = 1'b0; din = 8'h00;
    @(negedge clk);
    tick_run = 1'b1;
    step(); step();
    chk("rst_scl", scl, 1'b1);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_ackerr", ack_err, 1'b0);
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 10; i++) step();
    chk("idle_no_scl", nrise, 0);
    chk("idle_scl", scl, 1'b1);

    run_txn("a5_ack",  8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 44, 16'({8'hA5, 2'b10}), 10, 1, 1'b1);
    run_txn("a5_nack", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 44, 16'({8'hA5, 2'b10}), 10, 1, 1'b1);
    sda_in = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("nack_held", ack_err, 1'b1);

    run_txn("w40_nostop", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 40, 16'({8'h40, 1'b1}), 9, 0, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("held_scl", scl, 1'b0);
    chk("held_oe", sda_oe, 1'b1);
    run_txn("w3c_rstart", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 44, 16'({1'b1, 8'h3C, 2'b10}), 11, 1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("released_scl", scl, 1'b1);
    chk("released_oe", sda_oe, 1'b0);

    run_txn("busy_poke", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 44, 16'({8'h5A, 2'b10}), 10, 1, 1'b1);
    run_txn("same_tick", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 44, 16'({8'hC3, 2'b10}), 10, 1, 1'b1);

    din = 8'h12; gen_start = 1'b1; gen_stop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && tick_cnt < 22; i++) step();
    chk("midrst_reached", tick_cnt, 22);
    dc = done_cnt;
    rst = 1'b1;
    step();
    chk("midrst_scl", scl, 1'b1);
    chk("midrst_oe", sda_oe, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("midrst_no_done", done_cnt, dc);
    run_txn("after_rst", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 44, 16'({8'hFF, 2'b10}), 10, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/iic_byte_writer.md
Name: iic_byte_writer

Overview:
- Byte-level I2C master write engine that sits directly downstream of the free-running `counter` clock divider.
- It consumes the divider's one-cycle carry-out pulse as a quarter-SCL-period strobe (`tick`), and drives SCL and open-drain SDA.
- Per transaction: optional START, DW data bits MSB first, ACK sample, optional STOP.
- Used by the APDAQ IIC subsystem to write address and data bytes to slave devices.

Parameters:
- DW, 8, data bits per transaction (MSB first)

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  quarter-period strobe, one-cycle pulse from the divider counter's carry-out.
- start  in  1  transaction request; accepted only when ready=1.
- gen_start  in  1  emit START (or repeated START) before the data; sampled at accept.
- gen_stop  in  1  emit STOP after ACK; sampled at accept.
- din  in  DW  byte to transmit; latched at accept.
- sda_in  in  1  SDA line level (for ACK).
- ready  out  1  idle, able to accept.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  1 = slave NACKed last transaction.
- scl  out  1  SCL level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.

Behaviour:
- Reset (rst=1 at a clk edge): scl=1, sda_oe=0, ready=1, done=0, ack_err=0, bus_held=0.
  - Reset aborts any transaction mid-flight at the next edge; no done pulse.
- Accept: ready & start at an edge.
  - Latch din, gen_start, gen_stop; clear ack_err; ready=0.
  - Enter first segment at phase q=0 on the next cycle.
  - start with ready=0 is ignored; din changes after accept have no effect.
- Phase advance: q (0..3) advances only on tick. tick while idle is ignored. tick in the accept cycle is not counted.
  - The first phase may therefore be shorter than a full tick period.
- Segments are 4 phases each. Outputs are listed as (scl, sda_oe) for q0..q3:
  - START: q0 = (bus_held ? 0 : 1, 0); q1 = (1, 0); q2 = (1, 1); q3 = (0, 1). SDA falls while SCL is high.
  - BIT k (k = DW-1 down to 0): q0..q3 scl = 0, 1, 1, 0; sda_oe = ~din[k] for all four phases.
  - ACK: q0..q3 scl = 0, 1, 1, 0; sda_oe = 0. sda_in is registered into ack_err on the tick ending q1.
  - STOP: q0 = (0, 1); q1 = (1, 1); q2 = (1, 1); q3 = (1, 0). SDA rises while SCL is high.
- FSM states: IDLE → [START if gen_start] → BIT × DW → ACK → [STOP if gen_stop] → IDLE.
  - Transitions occur on the tick ending q3.
  - The bit counter decrements on each BIT segment end.
- Completion: on the tick ending the last segment, the next cycle has done=1 (one cycle) and ready=1.
  - With gen_stop=1: bus_held=0; idle outputs are scl=1, sda_oe=0.
  - With gen_stop=0: bus_held=1; scl held 0, sda_oe held at 1 until the next accept.
- Transaction length in ticks: 4·DW + 4 + 4·gen_start + 4·gen_stop. For DW=8 with START and STOP, this is 44.
- A NACK does not abort: the STOP (if requested) is still generated, and ack_err stays 1 until the next accept.
- No clock stretching and no arbitration; sda_in is used only in ACK.

Test Plan:
- Reset: rst=1 for 2 clk with tick running every 4 clk → scl=1, sda_oe=0, ready=1, done=0, ack_err=0; no SCL activity.
- Write din=0xA5, gen_start=1, gen_stop=1, sda_in=0 during ACK, tick every 4 clk:
  - SDA value at each SCL rise is 1,0,1,0,0,1,0,1.
  - START seen as SDA fall while SCL=1; STOP seen as SDA rise while SCL=1.
  - done pulse 1 cycle after the 44th tick; ack_err=0.
- Same as above with sda_in=1 during ACK → ack_err=1 after ACK, STOP still generated, done after 44 ticks, ack_err held until next accept.
- Write 0x40 with gen_stop=0, then 0x3C with gen_start=1, gen_stop=1:
  - Between transactions scl=0, sda_oe=1.
  - Second START q0 has scl=0, then a repeated START.
  - Transaction lengths are 40 and 44 ticks; two done pulses.
- rst=1 during BIT segment 4 → next edge scl=1, sda_oe=0, ready=1, no done; a new start with 0xFF then completes normally.
- start pulsed while busy with a different din → ignored, transmitted bits unchanged. start and tick in the same idle cycle → accepted, that tick not counted, length still 44 ticks.
